ddr_rd_arbiter: RTL

// - Shares the single LiteDRAM AXI read port (AR/R, user_clk domain, after the AXI CDC) between two read masters.
// - Master 0 is the SweRV SoC RAM port; master 1 is a secondary reader (DMA / debug).
// - Round-robin grant, one burst in flight, grant held until the last R beat.
// - Checks the beat count against ARLEN and keeps all traffic blocked until DDR init is done.

---
 rtl/ddr_rd_arbiter_if.sv | 34 +++
 rtl/ddr_rd_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter_if.sv
// AXI read-channel bundle for the LiteDRAM read arbiter: two upstream masters (s_*) and one DRAM port (m_*).
// slave is the arbiter's view; master is the view of the surrounding masters and DRAM.
interface ddr_rd_arbiter_if #(
    parameter int AW   = 32,
    parameter int IDW  = 6,
    parameter int DW   = 64,
    parameter int ARPL = AW + 8 + IDW,
    parameter int RPL  = DW + 2 + IDW
);
    logic [1:0]        s_ar_valid;
    logic [1:0]        s_ar_ready;
    logic [2*ARPL-1:0] s_ar_pl;
    logic [1:0]        s_r_valid;
    logic [1:0]        s_r_ready;
    logic [RPL-1:0]    s_r_pl;
    logic              s_r_last;
    logic              m_ar_valid;
    logic              m_ar_ready;
    logic [ARPL-1:0]   m_ar_pl;
    logic              m_r_valid;
    logic              m_r_ready;
    logic [RPL-1:0]    m_r_pl;
    logic              m_r_last;

    modport slave (
        input  s_ar_valid, s_ar_pl, s_r_ready, m_ar_ready, m_r_valid, m_r_pl, m_r_last,
        output s_ar_ready, s_r_valid, s_r_pl, s_r_last, m_ar_valid, m_ar_pl, m_r_ready
    );

    modport master (
        output s_ar_valid, s_ar_pl, s_r_ready, m_ar_ready, m_r_valid, m_r_pl, m_r_last,
        input  s_ar_ready, s_r_valid, s_r_pl, s_r_last, m_ar_valid, m_ar_pl, m_r_ready
    );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Round-robin sharing of the LiteDRAM AXI read port between two masters, one burst in flight, gated by DDR init.
// AR accepted in the grant cycle, m_ar_valid 1 cycle later and held until m_ar_ready; R is a combinational pass-through.
module ddr_rd_arbiter #(
    parameter int AW   = 32,
    parameter int IDW  = 6,
    parameter int DW   = 64,
    parameter int ARPL = AW + 8 + IDW,
    parameter int RPL  = DW + 2 + IDW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ram_init_done,
    ddr_rd_arbiter_if.slave bus,
    output logic            o_grant,
    output logic            o_busy,
    output logic            o_len_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_srv_q, last_srv_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [7:0]      len_q, len_d;
    logic [ARPL-1:0] ar_q, ar_d;
    logic            len_err_q, len_err_d;

    logic            win;
    logic [ARPL-1:0] win_pl;
    logic [1:0]      ar_rdy;
    logic [1:0]      r_vld;
    logic            r_rdy;
    logic            r_beat;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_srv_d = last_srv_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        ar_d       = ar_q;
        len_err_d  = len_err_q;
        ar_rdy     = 2'b00;
        r_vld      = 2'b00;
        r_rdy      = 1'b0;
        r_beat     = 1'b0;

        // on a tie the master that was not served last wins
        case (bus.s_ar_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_srv_q;
            default: win = 1'b0;
        endcase
        win_pl = win ? bus.s_ar_pl[ARPL +: ARPL] : bus.s_ar_pl[0 +: ARPL];

        case (state_q)
            IDLE: begin
                // rst gating keeps s_ar_ready low while reset holds the FSM in IDLE
                if (!rst && i_ram_init_done && (|bus.s_ar_valid)) begin
                    ar_rdy[win] = 1'b1;
                    grant_d     = win;
                    ar_d        = win_pl;
                    len_d       = win_pl[AW +: 8];
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (bus.m_ar_ready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                r_vld[grant_q] = bus.m_r_valid;
                r_rdy          = bus.s_r_ready[grant_q];
                r_beat         = bus.m_r_valid & r_rdy;
                if (r_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (bus.m_r_last) begin
                        if (beat_cnt_q != len_q) begin
                            len_err_d = 1'b1;
                        end
                        last_srv_d = grant_q;
                        state_d    = IDLE;
                    end else if (beat_cnt_q == len_q) begin
                        // overrun: flag it but keep the port until DRAM closes the burst
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_srv_q <= 1'b1;
            beat_cnt_q <= 8'd0;
            len_q      <= 8'd0;
            ar_q       <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_srv_q <= last_srv_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            ar_q       <= ar_d;
            len_err_q  <= len_err_d;
        end
    end

    assign bus.s_ar_ready = ar_rdy;
    assign bus.m_ar_valid = (state_q == ADDR);
    assign bus.m_ar_pl    = ar_q;
    assign bus.s_r_valid  = r_vld;
    assign bus.m_r_ready  = r_rdy;
    assign bus.s_r_pl     = (state_q == DATA) ? bus.m_r_pl : '0;
    assign bus.s_r_last   = (state_q == DATA) & bus.m_r_last;

    assign o_grant   = grant_q;
    assign o_busy    = (state_q != IDLE);
    assign o_len_err = len_err_q;
endmodule
